// File: rtl/dec_gpr_bank_ctl_pkg.sv
// Shared decode-stage definitions for the banked GPR file: bank-count defaults
// and the bank-switch sequencer state encoding.
package dec_gpr_bank_ctl_pkg;

    localparam int GPR_BANKS_DEF      = 4;
    localparam int GPR_BANKS_LOG2_DEF = $clog2(GPR_BANKS_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2,
        SETTLE = 2'd3
    } gpr_bank_state_e;

endpackage

// File: rtl/dec_gpr_bank_stack.sv
// LIFO of saved bank ids for nested traps. Pushes into a full stack and pops
// from an empty one are ignored; the caller reports those as errors.
module dec_gpr_bank_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  top_data,
    output logic [CW-1:0] depth,
    output logic          full,
    output logic          empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] top_ptr;

    assign top_ptr  = depth - 1'b1;
    assign top_data = mem[top_ptr[IW-1:0]];
    assign full     = (depth == CW'(DEPTH));
    assign empty    = (depth == '0);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            depth <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[depth[IW-1:0]] <= push_data;
            depth              <= depth + 1'b1;
        end else if (pop && !empty) begin
            depth <= depth - 1'b1;
        end
    end

endmodule

// File: rtl/dec_gpr_bank_ctl.sv
// Decode-stage bank-switch sequencer: accepts trap push/pop requests, drains
// GPR writebacks, then issues the one-cycle bank-id strobe to the register file.
module dec_gpr_bank_ctl
    import dec_gpr_bank_ctl_pkg::*;
#(
    parameter int GPR_BANKS      = GPR_BANKS_DEF,
    parameter int GPR_BANKS_LOG2 = GPR_BANKS_LOG2_DEF,
    parameter int STACK_DEPTH    = 4,
    parameter int DRAIN_CYCLES   = 3
) (
    input  logic                             clk,
    input  logic                             rst_l,
    input  logic                             push_req,
    input  logic [GPR_BANKS_LOG2-1:0]        push_bank,
    input  logic                             pop_req,
    output logic                             req_ready,
    input  logic                             wb_pending,
    output logic                             stall,
    output logic                             wen_bank_id,
    output logic [GPR_BANKS_LOG2-1:0]        wr_bank_id,
    output logic [GPR_BANKS_LOG2-1:0]        cur_bank,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             done,
    output logic                             err_overflow,
    output logic                             err_underflow,
    output gpr_bank_state_e                  state
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    if (GPR_BANKS < 2 || (1 << GPR_BANKS_LOG2) < GPR_BANKS) begin : g_bad_banks
        $error("dec_gpr_bank_ctl: GPR_BANKS_LOG2 too narrow for GPR_BANKS");
    end

    logic [GPR_BANKS_LOG2-1:0] target;
    logic [GPR_BANKS_LOG2-1:0] stk_top;
    logic [DCW-1:0]            drain_cnt;
    logic                      stk_full;
    logic                      stk_empty;
    logic                      push_acc;
    logic                      pop_acc;

    // Push wins a tie; a simultaneous pop stays pending until the next IDLE.
    assign push_acc  = (state == IDLE) && push_req;
    assign pop_acc   = (state == IDLE) && pop_req && !push_req;
    assign req_ready = (state == IDLE);
    assign stall     = (state != IDLE);

    dec_gpr_bank_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (GPR_BANKS_LOG2)
    ) u_stack (
        .clk       (clk),
        .rst_l     (rst_l),
        .push      (push_acc),
        .pop       (pop_acc),
        .push_data (cur_bank),
        .top_data  (stk_top),
        .depth     (depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state         <= IDLE;
            target        <= '0;
            drain_cnt     <= '0;
            cur_bank      <= '0;
            wen_bank_id   <= 1'b0;
            wr_bank_id    <= '0;
            done          <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            wen_bank_id   <= 1'b0;
            wr_bank_id    <= '0;
            done          <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (push_acc) begin
                        if (stk_full) begin
                            err_overflow <= 1'b1;
                        end else begin
                            target    <= push_bank;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end else if (pop_acc) begin
                        if (stk_empty) begin
                            err_underflow <= 1'b1;
                        end else begin
                            target    <= stk_top;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Any writeback activity restarts the full idle window.
                    if (wb_pending) begin
                        drain_cnt <= '0;
                    end else if (drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
                        drain_cnt   <= '0;
                        wen_bank_id <= 1'b1;
                        wr_bank_id  <= target;
                        state       <= SWITCH;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                SWITCH: begin
                    cur_bank <= target;
                    done     <= 1'b1;
                    state    <= SETTLE;
                end
                SETTLE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_gpr_bank_ctl.sv
// Bench for dec_gpr_bank_ctl: directed scenarios plus random push/pop traffic
// checked against a queue-based model of the saved-bank stack.
module tb_dec_gpr_bank_ctl;

    localparam int STACK_DEPTH  = 4;
    localparam int DRAIN_CYCLES = 3;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       push_req;
    logic [1:0] push_bank;
    logic       pop_req;
    logic       req_ready;
    logic       wb_pending;
    logic       stall;
    logic       wen_bank_id;
    logic [1:0] wr_bank_id;
    logic [1:0] cur_bank;
    logic [2:0] depth;
    logic       done;
    logic       err_overflow;
    logic       err_underflow;
    logic [1:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] m_stack[$];
    logic [1:0] m_cur;
    logic [1:0] exp_q[$];

    dec_gpr_bank_ctl #(
        .GPR_BANKS      (4),
        .GPR_BANKS_LOG2 (2),
        .STACK_DEPTH    (STACK_DEPTH),
        .DRAIN_CYCLES   (DRAIN_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .push_req      (push_req),
        .push_bank     (push_bank),
        .pop_req       (pop_req),
        .req_ready     (req_ready),
        .wb_pending    (wb_pending),
        .stall         (stall),
        .wen_bank_id   (wen_bank_id),
        .wr_bank_id    (wr_bank_id),
        .cur_bank      (cur_bank),
        .depth         (depth),
        .done          (done),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .state         (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with the DUT idle; returns just after
    // the rising edge that brings it back to idle.
    task automatic do_op(input bit is_push, input logic [1:0] bank, input int wb_pct,
                         input int wb_hot, input bit hold_pop);
        int         run;
        int         cyc;
        bit         drained;
        logic [1:0] tgt;
        push_req   = is_push;
        pop_req    = !is_push || hold_pop;
        push_bank  = bank;
        wb_pending = 1'b0;
        @(negedge clk);
        check_val("idle_ready", req_ready, 1);
        check_val("idle_stall", stall, 0);
        check_val("idle_done", done, 0);
        check_val("idle_errs", {err_overflow, err_underflow}, 0);
        check_val("idle_wen", wen_bank_id, 0);
        check_val("idle_cur", cur_bank, m_cur);
        @(posedge clk);
        #1;
        push_req = 1'b0;
        if (!hold_pop) pop_req = 1'b0;
        if (is_push && m_stack.size() == STACK_DEPTH) begin
            @(negedge clk);
            check_val("ovf_pulse", err_overflow, 1);
            check_val("ovf_no_unf", err_underflow, 0);
            check_val("ovf_stall", stall, 0);
            check_val("ovf_wen", wen_bank_id, 0);
            check_val("ovf_depth", depth, m_stack.size());
            check_val("ovf_cur", cur_bank, m_cur);
            @(posedge clk);
            #1;
            return;
        end
        if (!is_push && m_stack.size() == 0) begin
            @(negedge clk);
            check_val("unf_pulse", err_underflow, 1);
            check_val("unf_no_ovf", err_overflow, 0);
            check_val("unf_stall", stall, 0);
            check_val("unf_wen", wen_bank_id, 0);
            check_val("unf_depth", depth, 0);
            check_val("unf_cur", cur_bank, m_cur);
            @(posedge clk);
            #1;
            return;
        end
        if (is_push) begin
            tgt = bank;
            m_stack.push_back(m_cur);
        end else begin
            tgt = m_stack.pop_back();
        end
        exp_q.push_back(tgt);
        run     = 0;
        cyc     = 0;
        drained = 1'b0;
        while (!drained && cyc < 200) begin
            cyc++;
            wb_pending = (cyc == wb_hot) || ($urandom_range(0, 99) < wb_pct);
            @(negedge clk);
            check_val("drain_stall", stall, 1);
            check_val("drain_ready", req_ready, 0);
            check_val("drain_wen", wen_bank_id, 0);
            check_val("drain_depth", depth, m_stack.size());
            check_val("drain_cur", cur_bank, m_cur);
            if (wb_pending) run = 0;
            else run++;
            if (run == DRAIN_CYCLES) drained = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!drained) check_val("drain_budget", 0, 1);
        wb_pending = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_val("strobe_wen", wen_bank_id, 1);
        check_val("strobe_id", wr_bank_id, exp_q.pop_front());
        check_val("strobe_cur_old", cur_bank, m_cur);
        check_val("strobe_done", done, 0);
        check_val("strobe_stall", stall, 1);
        @(posedge clk);
        #1;
        m_cur = tgt;
        @(negedge clk);
        check_val("settle_wen", wen_bank_id, 0);
        check_val("settle_wr_zero", wr_bank_id, 0);
        check_val("settle_done", done, 1);
        check_val("settle_cur", cur_bank, m_cur);
        check_val("settle_stall", stall, 1);
        check_val("settle_depth", depth, m_stack.size());
        @(posedge clk);
        #1;
        wb_pending = 1'b0;
    endtask

    task automatic reset_mid(input int n_after);
        push_req  = 1'b1;
        push_bank = 2'd3;
        @(negedge clk);
        check_val("rst_pre_ready", req_ready, 1);
        @(posedge clk);
        #1;
        push_req = 1'b0;
        repeat (n_after) @(posedge clk);
        @(negedge clk);
        check_val("rst_pre_wen", wen_bank_id, (n_after == DRAIN_CYCLES) ? 1 : 0);
        check_val("rst_pre_stall", stall, 1);
        #1;
        rst_l = 1'b0;
        #1;
        m_stack.delete();
        m_cur = 2'd0;
        check_val("rst_stall", stall, 0);
        check_val("rst_ready", req_ready, 1);
        check_val("rst_cur", cur_bank, 0);
        check_val("rst_depth", depth, 0);
        check_val("rst_wen", wen_bank_id, 0);
        check_val("rst_done", done, 0);
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("post_rst_wen", wen_bank_id, 0);
            check_val("post_rst_stall", stall, 0);
            check_val("post_rst_cur", cur_bank, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l      = 1'b0;
        push_req   = 1'b0;
        pop_req    = 1'b0;
        push_bank  = 2'd0;
        wb_pending = 1'b0;
        m_cur      = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_ready", req_ready, 1);
        check_val("reset_stall", stall, 0);
        check_val("reset_cur", cur_bank, 0);
        check_val("reset_depth", depth, 0);
        check_val("reset_wen", wen_bank_id, 0);
        check_val("reset_done", done, 0);
        check_val("reset_errs", {err_overflow, err_underflow}, 0);
        rst_l = 1'b1;
        @(posedge clk);
        #1;

        do_op(1, 2'd2, 0, 0, 0);
        do_op(0, 2'd0, 0, 0, 0);
        do_op(1, 2'd2, 0, 2, 0);
        do_op(0, 2'd0, 0, 0, 0);

        do_op(1, 2'd1, 0, 0, 0);
        do_op(1, 2'd2, 0, 0, 0);
        do_op(1, 2'd3, 0, 0, 0);
        repeat (3) do_op(0, 2'd0, 0, 0, 0);

        do_op(1, 2'd1, 0, 0, 0);
        do_op(1, 2'd2, 0, 0, 0);
        do_op(1, 2'd3, 0, 0, 0);
        do_op(1, 2'd0, 0, 0, 0);
        do_op(1, 2'd1, 0, 0, 0);
        repeat (4) do_op(0, 2'd0, 0, 0, 0);
        do_op(0, 2'd0, 0, 0, 0);

        do_op(1, 2'd0, 0, 0, 0);
        do_op(1, 2'd1, 0, 0, 1);
        do_op(0, 2'd0, 0, 0, 0);
        do_op(0, 2'd0, 0, 0, 0);

        reset_mid(1);
        reset_mid(DRAIN_CYCLES);

        for (int i = 0; i < 60; i++) begin
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 25, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_gpr_bank_ctl.md
# dec_gpr_bank_ctl

Sequencer for the banked GPR file in the decode stage: accepts bank-switch requests on trap entry (push) and trap return (pop), and drains in-flight GPR writebacks. It then drives the register file's one-cycle bank-id write strobe and reports the active bank. A LIFO of saved bank ids supports nested traps; decode is stalled for the whole switch so no read or write ever straddles two banks.

## Interface
- GPR_BANKS, 4, number of register banks (≥2)
- GPR_BANKS_LOG2, 2, bank-id width, $clog2(GPR_BANKS)
- STACK_DEPTH, 4, saved-bank LIFO entries (≥1)
- DRAIN_CYCLES, 3, consecutive writeback-idle cycles required before switching (≥1)

Ports:
- clk  in  1  clock; one clock domain, all state on rising edge
- rst_l  in  1  asynchronous active-low reset
- push_req  in  1  trap entry: save current bank, switch to push_bank
- push_bank  in  GPR_BANKS_LOG2  target bank for push
- pop_req  in  1  trap return: restore most recently saved bank
- req_ready  out  1  request accepted this cycle if asserted
- wb_pending  in  1  any GPR write port (wen0/1/2) active or in flight
- stall  out  1  hold decode/issue
- wen_bank_id  out  1  bank-id write strobe to register file
- wr_bank_id  out  GPR_BANKS_LOG2  bank id written with wen_bank_id
- cur_bank  out  GPR_BANKS_LOG2  active bank, mirrors register-file bank flop
- depth  out  $clog2(STACK_DEPTH+1)  saved entries in LIFO
- done  out  1  one-cycle pulse, switch complete
- err_overflow  out  1  one-cycle pulse, push with LIFO full
- err_underflow  out  1  one-cycle pulse, pop with LIFO empty

## Operation
- FSM states: IDLE, DRAIN, SWITCH, SETTLE.
- req_ready = (state==IDLE). A request is accepted when it is asserted with req_ready. Requesters hold the request until accepted.
- Simultaneous push_req and pop_req: push accepted, pop not accepted and must be held.
- Push accept, depth<STACK_DEPTH: lifo[depth]<=cur_bank, depth+1, target<=push_bank, go to DRAIN.
- Pop accept, depth>0: target<=lifo[depth-1], depth-1, go to DRAIN.
- Push with depth==STACK_DEPTH: err_overflow pulses next cycle. No LIFO change, no switch, stay IDLE.
- Pop with depth==0: err_underflow pulses next cycle. No change, stay IDLE.
- Push with push_bank==cur_bank performs the full sequence; the strobe is still issued.
- DRAIN: drain counter increments on !wb_pending and clears on wb_pending. Go to SWITCH when !wb_pending and counter==DRAIN_CYCLES-1.
- SWITCH: wen_bank_id=1, wr_bank_id=target for exactly one cycle. cur_bank<=target at the same edge. Go to SETTLE.
- SETTLE: done=1 for one cycle, then go to IDLE.
- stall = (state!=IDLE).
- wr_bank_id = 0 whenever wen_bank_id=0.

## Timing
- Reset (async assert, sync release): state IDLE, cur_bank 0, depth 0, drain counter 0, LIFO contents 0, done/err_* 0, wen_bank_id 0, stall 0, req_ready 1. This matches the register file's bank flop, which also resets to 0.
- Request accepted in cycle T, wb_pending low throughout:
  - DRAIN occupies T+1..T+DRAIN_CYCLES.
  - wen_bank_id asserts at T+DRAIN_CYCLES+1.
  - cur_bank and done update at T+DRAIN_CYCLES+2.
  - req_ready returns at T+DRAIN_CYCLES+3.
- Each wb_pending high cycle in DRAIN restarts the full DRAIN_CYCLES count.
- Reset mid-sequence abandons the switch. No strobe is issued after rst_l deasserts.
- Next request may be accepted in the first IDLE cycle. There is no back-to-back accept before SETTLE completes.

## Structure
- Shared decode package: state enum gpr_bank_state_e (IDLE, DRAIN, SWITCH, SETTLE) and default GPR_BANKS/GPR_BANKS_LOG2 constants, so this block and the register file use identical widths.
- Sub-module dec_gpr_bank_stack: parameterized LIFO with push/pop/data/depth/full/empty and async active-low reset. The FSM, drain counter and error pulses stay in this block.
- All flops use the codebase's standard flop cells with rst_l.

## Test plan
- DRAIN_CYCLES=3, push_req with push_bank=2 at T, wb_pending=0 → wen_bank_id=1, wr_bank_id=2 at T+4; cur_bank=2, done=1 at T+5; depth=1; stall high T+1..T+5.
- Same push, wb_pending high at T+2 only → strobe delayed to T+6; no strobe while wb_pending=1.
- Nested pushes to banks 1,2,3, then three pops → cur_bank sequence 1,2,3,2,1,0; depth 1,2,3,2,1,0.
- Fill LIFO to STACK_DEPTH=4, fifth push → err_overflow pulse, depth stays 4, no wen_bank_id, cur_bank unchanged. Pop with depth 0 → err_underflow pulse only.
- push_req and pop_req together at depth 1 → push accepted (depth 2); pop accepted at first IDLE after done (depth 1).
- rst_l low during DRAIN and SWITCH cycles → immediately IDLE, cur_bank 0, depth 0, stall 0; no strobe after release.
